// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank driver: command opcodes, driver FSM states and
// the per-bit JK next-state helper used wherever a bank value is predicted.
package jk_bank_pkg;

    // Command opcodes; 101-111 are reserved and behave as NOP
    typedef logic [2:0] jkOp_t;

    localparam jkOp_t OP_NOP    = 3'b000;
    localparam jkOp_t OP_CLEAR  = 3'b001;
    localparam jkOp_t OP_SET    = 3'b010;
    localparam jkOp_t OP_TOGGLE = 3'b011;
    localparam jkOp_t OP_LOAD   = 3'b100;

    // Driver sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        CHECK = 3'd4
    } jkState_t;

    // Standard JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle
    function automatic logic jkNextBit(input logic jIn, input logic kIn, input logic qIn);
        logic result;
        unique case ({jIn, kIn})
            2'b00:   result = qIn;
            2'b01:   result = 1'b0;
            2'b10:   result = 1'b1;
            default: result = ~qIn;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/jk_excite_encode.sv
// Combinational command-to-excitation encoder: turns an opcode, mask and load
// data into per-bit j/k values, and predicts the bank value after one edge.
module jk_excite_encode
    import jk_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  jkOp_t            op,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] qNow,
    output logic [WIDTH-1:0] jNext,
    output logic [WIDTH-1:0] kNext,
    output logic [WIDTH-1:0] expected
);

    // Per-bit excitation; unmasked bits and NOP/reserved ops hold (j=k=0)
    always_comb begin
        jNext = '0;
        kNext = '0;
        case (op)
            OP_CLEAR: begin
                kNext = mask;
            end
            OP_SET: begin
                jNext = mask;
            end
            OP_TOGGLE: begin
                jNext = mask;
                kNext = mask;
            end
            OP_LOAD: begin
                jNext = mask & data;
                kNext = mask & ~data;
            end
            default: begin
                jNext = '0;
                kNext = '0;
            end
        endcase
    end

    // Predicted bank value after exactly one clock edge with this excitation
    always_comb begin
        expected = qNow;
        for (int i = 0; i < int'(WIDTH); i++) begin
            expected[i] = jkNextBit(jNext[i], kNext[i], qNow[i]);
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Command-side driver for a bank of JK flip-flops. Accepts one command per
// valid/ready handshake, holds j/k stable, issues exactly one registered
// rising edge on jkClk, then optionally verifies the bank readback.
// Optional feature macro: JK_READBACK_CHECK_EN (adds the CHECK state, the
// expected-value register and the sticky error flag).
module jk_bank_driver
    import jk_bank_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned HIGH_CYCLES  = 1
) (
    input  logic             MasterClock,
    input  logic             resetL,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [2:0]       cmdOp,
    input  logic [WIDTH-1:0] cmdMask,
    input  logic [WIDTH-1:0] cmdData,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             jkClk,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic             errorClr
);

    // One counter serves both timed phases; it always reloads, so never wraps
    localparam int unsigned MAX_CYCLES = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    jkState_t         state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [WIDTH-1:0] jNext;
    logic [WIDTH-1:0] kNext;
    logic [WIDTH-1:0] expectedNext;

    assign accept = cmdValid && cmdReady;

    jk_excite_encode #(
        .WIDTH(WIDTH)
    ) uEncode (
        .op      (jkOp_t'(cmdOp)),
        .mask    (cmdMask),
        .data    (cmdData),
        .qNow    (q),
        .jNext   (jNext),
        .kNext   (kNext),
        .expected(expectedNext)
    );

    // Command sequencer; every output is registered so jkClk cannot glitch
    always_ff @(posedge MasterClock or negedge resetL) begin
        if (!resetL) begin
            state    <= IDLE;
            cnt      <= '0;
            j        <= '0;
            k        <= '0;
            jkClk    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cmdReady <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmdReady <= 1'b1;
                    if (accept) begin
                        state    <= SETUP;
                        cnt      <= CNT_W'(SETUP_CYCLES - 1);
                        j        <= jNext;
                        k        <= kNext;
                        busy     <= 1'b1;
                        cmdReady <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(HIGH_CYCLES - 1);
                        jkClk <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        state <= LOW;
                        jkClk <= 1'b0;
`ifndef JK_READBACK_CHECK_EN
                        done  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                LOW: begin
`ifdef JK_READBACK_CHECK_EN
                    state <= CHECK;
                    done  <= 1'b1;
`else
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cmdReady <= 1'b1;
                    j        <= '0;
                    k        <= '0;
`endif
                end
`ifdef JK_READBACK_CHECK_EN
                CHECK: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cmdReady <= 1'b1;
                    j        <= '0;
                    k        <= '0;
                end
`endif
                default: begin
                    state    <= IDLE;
                    jkClk    <= 1'b0;
                    busy     <= 1'b0;
                    cmdReady <= 1'b0;
                    j        <= '0;
                    k        <= '0;
                end
            endcase
        end
    end

`ifdef JK_READBACK_CHECK_EN
    logic [WIDTH-1:0] expectedQ;
    logic             mismatch;

    // Bank value predicted from q as sampled in the accept cycle
    always_ff @(posedge MasterClock or negedge resetL) begin
        if (!resetL) begin
            expectedQ <= '0;
        end else if (accept) begin
            expectedQ <= expectedNext;
        end
    end

    assign mismatch = (state == CHECK) && (q != expectedQ);

    // Sticky readback error; a new mismatch beats a simultaneous clear
    always_ff @(posedge MasterClock or negedge resetL) begin
        if (!resetL) begin
            error <= 1'b0;
        end else if (mismatch) begin
            error <= 1'b1;
        end else if (errorClr) begin
            error <= 1'b0;
        end
    end
`else
    logic unusedReadback;

    // Readback path is absent in this build
    assign error          = 1'b0;
    assign unusedReadback = ^{errorClr, expectedNext};
`endif

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Command-side driver for a bank of WIDTH JK flip-flop cells. It is the producer of the j/k/clk signals that the JK cells consume.
- Accepts set/clear/toggle/load commands over a valid/ready handshake and converts each into per-bit j/k excitation. It then issues one clean rising edge on jkClk, all in the MasterClock domain.
- Optionally reads back q to confirm that the bank reached the expected value.
- Sits between CPU-side register logic and gate-level JK register banks.

Parameters:
- WIDTH, 8, number of JK cells driven.
- SETUP_CYCLES, 1, MasterClock cycles that j/k are held stable with jkClk low before the edge (minimum 1).
- HIGH_CYCLES, 1, MasterClock cycles that jkClk stays high (minimum 1).

Ports:
- MasterClock  in  1  sole clock; all state changes on its rising edge.
- resetL  in  1  asynchronous, active-low reset.
- cmdValid  in  1  command present.
- cmdReady  out  1  driver can accept a command.
- cmdOp  in  3  000 NOP, 001 CLEAR, 010 SET, 011 TOGGLE, 100 LOAD; 101-111 reserved (treated as NOP).
- cmdMask  in  WIDTH  bits affected; unmasked bits get j=0, k=0.
- cmdData  in  WIDTH  LOAD value.
- j  out  WIDTH  J inputs to bank.
- k  out  WIDTH  K inputs to bank.
- jkClk  out  1  clock to bank; registered, glitch-free.
- q  in  WIDTH  bank readback.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- error  out  1  sticky readback mismatch.
- errorClr  in  1  clears error.

Behaviour:
- Reset (resetL=0, async):
  - j=0, k=0, jkClk=0, busy=0, done=0, error=0, cmdReady=0.
  - FSM goes to IDLE. cmdReady rises in the first cycle after resetL deasserts.
- Reset mid-command aborts the command immediately. jkClk drops asynchronously; no partial edge is issued afterwards.
- Handshake:
  - A command is accepted on a cycle where cmdValid && cmdReady.
  - cmdReady=1 only in IDLE.
  - cmdOp/cmdMask/cmdData are captured at acceptance; later input changes are ignored.
- Excitation per masked bit i, registered at acceptance:
  - CLEAR: j=0, k=1.
  - SET: j=1, k=0.
  - TOGGLE: j=1, k=1.
  - LOAD: j=cmdData[i], k=~cmdData[i].
  - NOP/reserved: j=0, k=0 for all bits.
- Expected value is computed at acceptance from q sampled in that cycle, using the standard JK table per bit.
- FSM:
  - IDLE: cmdReady=1. On accept -> SETUP with counter=SETUP_CYCLES-1.
  - SETUP: jkClk=0, j/k held. Counter reaches 0 -> HIGH.
  - HIGH: jkClk=1, entered by registered assertion so the rising edge is exactly one per command. After HIGH_CYCLES -> LOW.
  - LOW: jkClk=0 for one cycle, j/k still held (hold time) -> CHECK.
  - CHECK: compare q against expected. Mismatch sets error. done=1 for this cycle. j/k return to 0 the next cycle. -> IDLE.
- busy=1 in every state except IDLE.
- Latency: accept to done = SETUP_CYCLES + HIGH_CYCLES + 2 cycles. A back-to-back command can be accepted the cycle after done.
- NOP still issues a clk edge (bank holds) and completes normally.
- error and errorClr:
  - errorClr clears error.
  - A simultaneous errorClr and mismatch leaves error=1 (set wins).
- Counter widths are sized by $clog2 of the parameter + 1. No wrap is possible because the counters always reload from the parameter.

Optional Feature:
- Macro JK_READBACK_CHECK_EN.
- Defined: CHECK state as above; the q comparison drives error.
- Undefined:
  - CHECK state is omitted and LOW goes directly to IDLE, asserting done in LOW.
  - Latency becomes SETUP_CYCLES + HIGH_CYCLES + 1.
  - error is tied to 0, errorClr and q are unused, and no expected-value register is built.

Decomposition:
- Package jk_bank_pkg holds:
  - opcode constants OP_NOP, OP_CLEAR, OP_SET, OP_TOGGLE, OP_LOAD as a 3-bit typedef.
  - FSM state typedef (IDLE, SETUP, HIGH, LOW, CHECK).
- One combinational sub-module, jk_excite_encode. Inputs op/mask/data/qNow; outputs jNext, kNext, expected. It is shared with a future bank model and reused by the bench as the reference.

Test Plan:
- Reset then SET, mask 0x0F, q=0x00 -> j=0x0F, k=0x00 during SETUP; one jkClk rising edge; bank q=0x0F; done after 4 cycles; error=0.
- TOGGLE, mask 0xFF, q=0xA5 -> j=k=0xFF; q becomes 0x5A; error stays 0.
- LOAD data 0x3C, mask 0xF0, q=0x81 -> j=0x30, k=0xC0; q becomes 0x31.
- Bank model forced to ignore bit 0, SET mask 0x01 -> error=1 after CHECK. errorClr pulsed together with a new mismatch -> error remains 1. Next clean command with errorClr -> error=0.
- cmdValid held high with changing data -> exactly one accept per done. Accepted fields stay stable. Reserved op 110 -> j=k=0, single edge, done.
- resetL low during HIGH -> jkClk=0 and j=k=0 immediately. After release, no edge occurs until a new command. Also build without JK_READBACK_CHECK_EN -> latency is 3 cycles for defaults and error stays 0.
